// File: rtl/trigger_delay_pkg.sv
// rtl/trigger_delay_pkg.sv - command kinds, opcodes and frame helpers for the trigger-delay host
package trigger_delay_pkg;

   typedef enum logic [2:0] {
      KIND_SET_DELAY   = 3'd0,
      KIND_GET_DELAY   = 3'd1,
      KIND_SET_EDGE    = 3'd2,
      KIND_GET_EDGE    = 3'd3,
      KIND_GET_STATUS  = 3'd4,
      KIND_RESET_COUNT = 3'd5
   } cmd_kind_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TX_BYTE = 3'd1,
      S_TX_WAIT = 3'd2,
      S_RX_WAIT = 3'd3,
      S_DONE    = 3'd4
   } host_state_t;

   localparam logic [7:0] CMD_SET_DELAY   = 8'h01;
   localparam logic [7:0] CMD_GET_DELAY   = 8'h02;
   localparam logic [7:0] CMD_SET_EDGE    = 8'h03;
   localparam logic [7:0] CMD_GET_EDGE    = 8'h04;
   localparam logic [7:0] CMD_GET_STATUS  = 8'h05;
   localparam logic [7:0] CMD_RESET_COUNT = 8'h06;

   function automatic logic kind_valid(input logic [2:0] kind);
      return kind <= KIND_RESET_COUNT;
   endfunction

   function automatic logic [7:0] opcode(input logic [2:0] kind);
      case (kind)
         KIND_SET_DELAY:   return CMD_SET_DELAY;
         KIND_GET_DELAY:   return CMD_GET_DELAY;
         KIND_SET_EDGE:    return CMD_SET_EDGE;
         KIND_GET_EDGE:    return CMD_GET_EDGE;
         KIND_GET_STATUS:  return CMD_GET_STATUS;
         KIND_RESET_COUNT: return CMD_RESET_COUNT;
         default:          return 8'h00;
      endcase
   endfunction

   // Bytes sent including the opcode.
   function automatic logic [2:0] tx_len(input logic [2:0] kind);
      case (kind)
         KIND_SET_DELAY:   return 3'd5;
         KIND_SET_EDGE:    return 3'd2;
         KIND_GET_DELAY,
         KIND_GET_EDGE,
         KIND_GET_STATUS,
         KIND_RESET_COUNT: return 3'd1;
         default:          return 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] rx_len(input logic [2:0] kind);
      case (kind)
         KIND_GET_DELAY:  return 3'd4;
         KIND_GET_EDGE:   return 3'd1;
         KIND_GET_STATUS: return 3'd6;
         default:         return 3'd0;
      endcase
   endfunction

   function automatic logic [7:0] tx_byte(input logic [2:0] kind, input logic [31:0] data,
                                          input logic [2:0] idx);
      if (idx == 3'd0) return opcode(kind);
      if (kind == KIND_SET_EDGE) return {6'd0, data[1:0]};
      case (idx)
         3'd1:    return data[7:0];
         3'd2:    return data[15:8];
         3'd3:    return data[23:16];
         3'd4:    return data[31:24];
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/trigger_delay_host.sv
// rtl/trigger_delay_host.sv - UART command initiator: sends one request frame, collects the reply
module trigger_delay_host
   import trigger_delay_pkg::*;
#(
   parameter int CLK_FREQ       = 100_000_000,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_kind,
   input  logic [31:0] cmd_data,
   output logic        tx_en,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_data_valid,
   output logic        rsp_valid,
   output logic [47:0] rsp_data,
   output logic [2:0]  rsp_len,
   output logic        rsp_timeout,
   output logic        busy,
   output logic        stray_rx
);

   // A zero TIMEOUT_CYCLES falls back to a 1 ms window derived from the clock.
   localparam int EFF_TIMEOUT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : (CLK_FREQ / 1000);
   localparam int TW          = $clog2(EFF_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(EFF_TIMEOUT - 1);

   host_state_t   state, state_n;
   logic [2:0]    kind_q;
   logic [31:0]   data_q;
   logic [2:0]    idx;
   logic          tx_low_seen;
   logic [TW-1:0] timer;

   always_comb begin
      state_n   = state;
      cmd_ready = 1'b0;
      tx_en     = 1'b0;
      tx_data   = 8'h00;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_n = kind_valid(cmd_kind) ? S_TX_BYTE : S_DONE;
         end
         S_TX_BYTE: begin
            if (tx_ready) begin
               tx_en   = 1'b1;
               tx_data = tx_byte(kind_q, data_q, idx);
               state_n = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            // The byte is only on the wire once the UART has gone busy and back to idle.
            if (tx_low_seen && tx_ready) begin
               if (idx + 3'd1 < tx_len(kind_q)) state_n = S_TX_BYTE;
               else if (rx_len(kind_q) == 3'd0) state_n = S_DONE;
               else                             state_n = S_RX_WAIT;
            end
         end
         S_RX_WAIT: begin
            if (rx_data_valid) begin
               if (rsp_len + 3'd1 == rx_len(kind_q)) state_n = S_DONE;
            end else if (timer == TIMER_LAST) begin
               state_n = S_DONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         kind_q      <= 3'd0;
         data_q      <= 32'd0;
         idx         <= 3'd0;
         tx_low_seen <= 1'b0;
         timer       <= '0;
         rsp_data    <= 48'd0;
         rsp_len     <= 3'd0;
         rsp_timeout <= 1'b0;
         stray_rx    <= 1'b0;
      end else begin
         state    <= state_n;
         stray_rx <= rx_data_valid && (state != S_RX_WAIT);
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  kind_q      <= cmd_kind;
                  data_q      <= cmd_data;
                  idx         <= 3'd0;
                  tx_low_seen <= 1'b0;
                  rsp_data    <= 48'd0;
                  rsp_len     <= 3'd0;
                  rsp_timeout <= !kind_valid(cmd_kind);
               end
            end
            S_TX_BYTE: begin
               if (tx_ready) tx_low_seen <= 1'b0;
            end
            S_TX_WAIT: begin
               if (!tx_ready) begin
                  tx_low_seen <= 1'b1;
               end else if (tx_low_seen) begin
                  idx   <= idx + 3'd1;
                  timer <= '0;
               end
            end
            S_RX_WAIT: begin
               // A byte landing on the timeout cycle still counts and restarts the window.
               if (rx_data_valid) begin
                  for (int i = 0; i < 6; i++)
                     if (rsp_len == 3'(i)) rsp_data[8*i +: 8] <= rx_data;
                  rsp_len <= rsp_len + 3'd1;
                  timer   <= '0;
               end else if (timer == TIMER_LAST) begin
                  rsp_timeout <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state == S_DONE);
   assign busy      = !cmd_ready;

endmodule

// File: tb/tb_trigger_delay_host.sv
// tb/tb_trigger_delay_host.sv - self-checking bench for trigger_delay_host with a UART-side model
module tb_trigger_delay_host;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_kind = 3'd0;
   logic [31:0] cmd_data = 32'd0;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_data_valid = 1'b0;
   logic        rsp_valid;
   logic [47:0] rsp_data;
   logic [2:0]  rsp_len;
   logic        rsp_timeout;
   logic        busy;
   logic        stray_rx;

   trigger_delay_host #(.CLK_FREQ(100_000_000), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_kind(cmd_kind), .cmd_data(cmd_data), .tx_en(tx_en), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_len(rsp_len),
      .rsp_timeout(rsp_timeout), .busy(busy), .stray_rx(stray_rx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Protocol model: opcode table, frame contents and reply lengths.
   function automatic logic [7:0] m_opcode(input int k);
      case (k)
         0: return 8'h01;
         1: return 8'h02;
         2: return 8'h03;
         3: return 8'h04;
         4: return 8'h05;
         5: return 8'h06;
         default: return 8'h00;
      endcase
   endfunction

   function automatic int m_tx_len(input int k);
      if (k > 5) return 0;
      if (k == 0) return 5;
      if (k == 2) return 2;
      return 1;
   endfunction

   function automatic int m_rx_len(input int k);
      if (k == 1) return 4;
      if (k == 3) return 1;
      if (k == 4) return 6;
      return 0;
   endfunction

   function automatic logic [7:0] m_tx_byte(input int k, input logic [31:0] d, input int i);
      logic [31:0] sh;
      if (i == 0) return m_opcode(k);
      if (k == 2) return {6'd0, d[1:0]};
      sh = d >> (8 * (i - 1));
      return sh[7:0];
   endfunction

   // Shared state between UART model, monitor and stimulus.
   logic [7:0]  tx_log[$];
   int          tx_hold = 0;
   bit          tx_pending = 1'b0;
   int          last_ev = 0;
   bit          rsp_armed = 1'b0;
   int          rsp_seen = 0;
   logic [47:0] exp_data;
   int          exp_len;
   bit          exp_to;
   int          exp_rx;
   logic [47:0] cap_data;
   int          cap_len;
   bit          cap_to;
   int          cap_lat;

   // UART_TX model: busy for three cycles after each strobe.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         tx_ready   = 1'b1;
         tx_hold    = 0;
         tx_pending = 1'b0;
      end else if (tx_hold > 0) begin
         tx_hold--;
         if (tx_hold == 0) begin
            tx_ready = 1'b1;
            last_ev  = cyc;
         end
      end else if (tx_pending) begin
         tx_pending = 1'b0;
         tx_ready   = 1'b0;
         tx_hold    = 3;
      end else if (tx_en) begin
         tx_log.push_back(tx_data);
         tx_pending = 1'b1;
      end
   end

   // Per-cycle compare against the model expectations.
   logic prev_tx_en = 1'b0;
   initial forever begin
      @(negedge clk);
      #2;
      if (rst) begin
         prev_tx_en = 1'b0;
      end else begin
         check("tx_en_adjacent", {63'd0, prev_tx_en & tx_en}, 64'd0);
         check("rsp_unexpected", {63'd0, rsp_valid & ~rsp_armed}, 64'd0);
         if (rsp_valid && rsp_armed) begin
            check("rsp_cycle", 64'(cyc - last_ev),
                  64'((exp_to && exp_rx > 0) ? T + 1 : 1));
            check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
            check("rsp_len", 64'(rsp_len), 64'(exp_len));
            check("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, exp_to});
            cap_data  = rsp_data;
            cap_len   = int'(rsp_len);
            cap_to    = rsp_timeout;
            cap_lat   = cyc - last_ev;
            rsp_armed = 1'b0;
            rsp_seen++;
         end
         prev_tx_en = tx_en;
      end
   end

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic run_cmd(input int k, input logic [31:0] d, input logic [47:0] reply,
                          input int n_reply);
      int n_store;
      int n_tx;
      int seen0;
      exp_rx   = m_rx_len(k);
      n_store  = (n_reply < exp_rx) ? n_reply : exp_rx;
      exp_data = 48'd0;
      for (int j = 0; j < n_store; j++) exp_data[8*j +: 8] = reply[8*j +: 8];
      exp_len  = n_store;
      exp_to   = (k > 5) || (n_reply < exp_rx);
      n_tx     = m_tx_len(k);
      tx_log.delete();
      for (int i = 0; i < 50 && !cmd_ready; i++) step();
      check("ready_before_accept", {63'd0, cmd_ready}, 64'd1);
      cmd_kind  = 3'(k);
      cmd_data  = d;
      cmd_valid = 1'b1;
      last_ev   = cyc;
      seen0     = rsp_seen;
      rsp_armed = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 300 && !(tx_log.size() == n_tx && tx_ready && tx_hold == 0 && !tx_pending); i++)
         step();
      check("tx_frame_len", 64'(tx_log.size()), 64'(n_tx));
      for (int i = 0; i < n_tx && i < tx_log.size(); i++)
         check("tx_frame_byte", {56'd0, tx_log[i]}, {56'd0, m_tx_byte(k, d, i)});
      for (int j = 0; j < n_reply; j++) begin
         step();
         step();
         rx_data       = reply[8*j +: 8];
         rx_data_valid = 1'b1;
         if (j < exp_rx) last_ev = cyc;
         step();
         rx_data_valid = 1'b0;
      end
      for (int i = 0; i < T + 40 && rsp_seen == seen0; i++) step();
      check("rsp_arrived", 64'(rsp_seen - seen0), 64'd1);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded at cycle %0d, required completion", cyc);
      $fatal(1);
   end

   initial begin
      repeat (3) step();
      rst = 1'b0;
      step();
      check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_tx_en", {63'd0, tx_en}, 64'd0);
      check("reset_tx_data", {56'd0, tx_data}, 64'd0);
      check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("reset_rsp_data", {16'd0, rsp_data}, 64'd0);
      check("reset_rsp_len", {61'd0, rsp_len}, 64'd0);
      check("reset_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
      check("reset_stray", {63'd0, stray_rx}, 64'd0);

      // SET_DELAY 0x12345678
      run_cmd(0, 32'h12345678, 48'd0, 0);
      check("set_delay_frame", tx_log.size() == 5 ? {24'd0, tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]} : 64'hDEAD,
            64'h0178563412);
      check("set_delay_len", 64'(cap_len), 64'd0);
      check("set_delay_to", {63'd0, cap_to}, 64'd0);

      // GET_DELAY with full reply
      run_cmd(1, 32'd0, 48'h000000002710, 4);
      check("get_delay_data", {32'd0, cap_data[31:0]}, 64'h2710);
      check("get_delay_len", 64'(cap_len), 64'd4);
      check("get_delay_to", {63'd0, cap_to}, 64'd0);

      // GET_STATUS: 05 00 E8 03 00 00
      run_cmd(4, 32'd0, 48'h000003E80005, 6);
      check("get_status_data", {16'd0, cap_data}, 64'h000003E80005);
      check("get_status_len", 64'(cap_len), 64'd6);

      // Stray byte while idle
      rx_data       = 8'hA5;
      rx_data_valid = 1'b1;
      step();
      rx_data_valid = 1'b0;
      check("stray_pulse", {63'd0, stray_rx}, 64'd1);
      check("stray_keeps_data", {16'd0, rsp_data}, 64'h000003E80005);
      step();
      check("stray_one_cycle", {63'd0, stray_rx}, 64'd0);

      // GET_EDGE with no reply
      run_cmd(3, 32'd0, 48'd0, 0);
      check("get_edge_to", {63'd0, cap_to}, 64'd1);
      check("get_edge_len", 64'(cap_len), 64'd0);
      check("get_edge_latency", 64'(cap_lat), 64'(T + 1));

      // GET_DELAY partial reply
      run_cmd(1, 32'd0, 48'h000000002710, 2);
      check("partial_to", {63'd0, cap_to}, 64'd1);
      check("partial_len", 64'(cap_len), 64'd2);
      check("partial_data", {48'd0, cap_data[15:0]}, 64'h2710);

      // SET_EDGE, RESET_COUNT, and GET_EDGE with a surplus byte
      run_cmd(2, 32'hFFFF_FFFE, 48'd0, 0);
      check("set_edge_payload", tx_log.size() == 2 ? {56'd0, tx_log[1]} : 64'hDEAD, 64'h02);
      run_cmd(5, 32'd0, 48'd0, 0);
      run_cmd(3, 32'd0, 48'h0000000077_01, 2);
      check("surplus_not_stored", {16'd0, rsp_data}, 64'h01);
      check("surplus_len", {61'd0, rsp_len}, 64'd1);

      // Invalid kind: nothing sent, immediate timeout
      run_cmd(7, 32'h0, 48'd0, 0);
      check("invalid_to", {63'd0, cap_to}, 64'd1);
      check("invalid_no_tx", 64'(tx_log.size()), 64'd0);

      // Reset while waiting for the UART to finish byte 1 of SET_DELAY
      tx_log.delete();
      cmd_kind  = 3'd0;
      cmd_data  = 32'hAABBCCDD;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 100 && !(tx_log.size() == 2 && !tx_ready); i++) step();
      check("rst_reached_tx_wait", 64'(tx_log.size()), 64'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_abort_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_abort_len", {61'd0, rsp_len}, 64'd0);
      repeat (8) step();
      check("rst_no_more_tx", 64'(tx_log.size()), 64'd2);

      // Recovery after abort
      run_cmd(1, 32'd0, 48'h0000DEADBEEF, 4);
      check("recover_data", {32'd0, cap_data[31:0]}, 64'hDEADBEEF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
